// File: rtl/bs_bit_reader_if.sv
// bs_bit_reader_if
// Groups the FIFO read port and the syntax-parser port of bs_bit_reader.
// The master modport is the bit reader itself; the slave modport is its
// surroundings (the bitstream FIFO and the parser).
// Optional macro: BS_BIT_COUNT_EN adds the bit_count signal.

interface bs_bit_reader_if;
   logic        fifo_rd;
   logic [63:0] fifo_data;
   logic        fifo_empty;
   logic [31:0] peek_bits;
   logic        peek_valid;
   logic        skip;
   logic [5:0]  skip_len;
   logic        byte_align;
   logic        flush;
`ifdef BS_BIT_COUNT_EN
   logic [31:0] bit_count;

   modport master (
      output fifo_rd, peek_bits, peek_valid, bit_count,
      input  fifo_data, fifo_empty, skip, skip_len, byte_align, flush
   );

   modport slave (
      input  fifo_rd, peek_bits, peek_valid, bit_count,
      output fifo_data, fifo_empty, skip, skip_len, byte_align, flush
   );
`else
   modport master (
      output fifo_rd, peek_bits, peek_valid,
      input  fifo_data, fifo_empty, skip, skip_len, byte_align, flush
   );

   modport slave (
      input  fifo_rd, peek_bits, peek_valid,
      output fifo_data, fifo_empty, skip, skip_len, byte_align, flush
   );
`endif
endinterface

// File: rtl/bs_bit_reader.sv
// bs_bit_reader
// Pulls 64-bit words from the bitstream FIFO into a 128-bit MSB-first shift
// buffer and offers a 32-bit look-ahead window to the syntax parser, which
// consumes 0..32 bits per cycle or discards up to the next byte boundary.
// Optional macro: BS_BIT_COUNT_EN adds a free-running consumed-bit counter.

module bs_bit_reader #(
   parameter int DATA_BITS = 64
) (
   input  logic             clk,
   input  logic             aclr,
   bs_bit_reader_if.master  bus
);

   localparam int BUF_BITS = 2 * DATA_BITS;

   logic [BUF_BITS-1:0] shift_buf;
   logic [7:0]          bits_valid;
   logic                rd_pending;
   logic                discard;
   logic [2:0]          pos_mod8;

   logic                peek_valid_int;
   logic                fifo_rd_int;
   logic [5:0]          consume_n;
   logic [7:0]          bits_left;
   logic                append;
   logic [BUF_BITS-1:0] shifted;
   logic [BUF_BITS-1:0] incoming;
   logic [BUF_BITS-1:0] buf_next;
   logic [7:0]          bits_next;

   // Look-ahead window, refill request and this cycle's consume amount.
   always_comb begin
      peek_valid_int = (bits_valid >= 8'd32);
      fifo_rd_int    = !aclr && !bus.flush && !bus.fifo_empty &&
                       !rd_pending && (bits_valid <= 8'd64);
      consume_n      = '0;
      if (bus.skip && peek_valid_int) begin
         consume_n = bus.skip_len;
      end else if (bus.byte_align && peek_valid_int) begin
         consume_n = {3'b000, 3'd0 - pos_mod8};
      end
   end

   // Shift out consumed bits and splice an arriving word right behind the survivors.
   always_comb begin
      bits_left = bits_valid - {2'b00, consume_n};
      append    = rd_pending && !discard;
      shifted   = shift_buf << consume_n;
      incoming  = {bus.fifo_data, {DATA_BITS{1'b0}}} >> bits_left;
      buf_next  = shifted | (append ? incoming : '0);
      bits_next = bits_left + (append ? 8'd64 : 8'd0);
   end

   assign bus.peek_bits  = shift_buf[BUF_BITS-1 -: 32];
   assign bus.peek_valid = peek_valid_int;
   assign bus.fifo_rd    = fifo_rd_int;

   // Buffer state; flush drops everything, including the word landing this cycle.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         shift_buf  <= '0;
         bits_valid <= '0;
         rd_pending <= 1'b0;
         discard    <= 1'b0;
         pos_mod8   <= '0;
      end else if (bus.flush) begin
         shift_buf  <= '0;
         bits_valid <= '0;
         rd_pending <= 1'b0;
         discard    <= rd_pending;
         pos_mod8   <= '0;
      end else begin
         shift_buf  <= buf_next;
         bits_valid <= bits_next;
         rd_pending <= fifo_rd_int;
         discard    <= 1'b0;
         pos_mod8   <= pos_mod8 + consume_n[2:0];
      end
   end

`ifdef BS_BIT_COUNT_EN
   logic [31:0] bit_count_q;

   // Running total of consumed bits, wrapping modulo 2^32.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         bit_count_q <= '0;
      end else if (bus.flush) begin
         bit_count_q <= '0;
      end else begin
         bit_count_q <= bit_count_q + {26'd0, consume_n};
      end
   end

   assign bus.bit_count = bit_count_q;
`endif

`ifndef SYNTHESIS
   // Trap an out-of-range skip length from the parser in simulation.
   always @(posedge clk) begin
      if (!aclr && bus.skip && (bus.skip_len > 6'd32)) begin
         $error("%m: skip_len %0d exceeds 32", bus.skip_len);
         $stop;
      end
   end
`endif

endmodule

// File: tb/tb_bs_bit_reader.sv
// tb_bs_bit_reader
// Directed scenarios followed by a random phase, all checked against a
// bit-queue reference model of the bitstream.
// Optional macro: BS_BIT_COUNT_EN enables the bit_count checks.

module tb_bs_bit_reader;

   logic clk  = 1'b0;
   logic aclr = 1'b1;

   bs_bit_reader_if bus ();

   bs_bit_reader dut (
      .clk  (clk),
      .aclr (aclr),
      .bus  (bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int          tests_run    = 0;
   int          tests_failed = 0;

   logic [63:0] fifo_q[$];
   bit          model_bits[$];
   bit          model_pending = 1'b0;
   int          model_pos     = 0;
   int unsigned model_count   = 0;

   localparam logic [63:0] W1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] W2 = 64'hFEDCBA9876543210;
   localparam logic [63:0] W3 = 64'h1122334455667788;
   localparam logic [63:0] W4 = 64'hCAFEF00DDEADBEEF;
   localparam logic [63:0] W5 = 64'h5A5AC3C30F0F9696;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic modelClear();
      model_bits.delete();
      model_pending = 1'b0;
      model_pos     = 0;
      model_count   = 0;
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance both.
   task automatic applyStimulus(input logic s, input logic [5:0] len,
                                input logic a, input logic f);
      logic [31:0] exp_peek;
      logic        exp_valid;
      logic        exp_rd;
      logic        rd_now;
      int          n;
      bus.skip       = s;
      bus.skip_len   = len;
      bus.byte_align = a;
      bus.flush      = f;
      bus.fifo_empty = (fifo_q.size() == 0);
      #1;
      exp_valid = (model_bits.size() >= 32);
      exp_peek  = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < model_bits.size()) exp_peek[31-i] = model_bits[i];
      end
      exp_rd = !bus.fifo_empty && !model_pending && (model_bits.size() <= 64) && !f;
      checkOutput("peek_bits", bus.peek_bits, exp_peek);
      checkOutput("peek_valid", {31'd0, bus.peek_valid}, {31'd0, exp_valid});
      checkOutput("fifo_rd", {31'd0, bus.fifo_rd}, {31'd0, exp_rd});
`ifdef BS_BIT_COUNT_EN
      checkOutput("bit_count", bus.bit_count, model_count);
`endif
      n = 0;
      if (s && exp_valid) n = int'(len);
      else if (a && exp_valid) n = (8 - model_pos) % 8;
      rd_now = bus.fifo_rd;
      @(posedge clk);
      if (f) begin
         model_bits.delete();
         model_pos   = 0;
         model_count = 0;
      end else begin
         for (int i = 0; i < n; i++) void'(model_bits.pop_front());
         model_pos   = (model_pos + n) % 8;
         model_count = model_count + n;
         if (model_pending) begin
            for (int i = 63; i >= 0; i--) model_bits.push_back(bus.fifo_data[i]);
         end
      end
      model_pending = exp_rd;
      #1;
      if (rd_now && fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
   endtask

   task automatic waitValid();
      for (int i = 0; i < 10 && !bus.peek_valid; i++) applyStimulus(0, 0, 0, 0);
      checkOutput("wait_valid", {31'd0, bus.peek_valid}, 32'd1);
   endtask

   // Hold aclr through an edge, check the cleared outputs, then release.
   task automatic doReset();
      aclr = 1'b1;
      @(posedge clk);
      #1;
      bus.fifo_empty = (fifo_q.size() == 0);
      #1;
      checkOutput("rst_peek_bits", bus.peek_bits, 32'd0);
      checkOutput("rst_peek_valid", {31'd0, bus.peek_valid}, 32'd0);
      checkOutput("rst_fifo_rd", {31'd0, bus.fifo_rd}, 32'd0);
`ifdef BS_BIT_COUNT_EN
      checkOutput("rst_bit_count", bus.bit_count, 32'd0);
`endif
      fifo_q.delete();
      bus.fifo_empty = 1'b1;
      modelClear();
      @(posedge clk);
      #1;
      aclr = 1'b0;
   endtask

   initial begin
      bus.fifo_data  = '0;
      bus.fifo_empty = 1'b1;
      bus.skip       = 1'b0;
      bus.skip_len   = '0;
      bus.byte_align = 1'b0;
      bus.flush      = 1'b0;

      // Reset with a word already waiting, so the read gating is exercised.
      fifo_q.push_back(W3);
      doReset();
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);

      // Cold start, then four 32-bit skips across two words.
      fifo_q.push_back(W1);
      fifo_q.push_back(W2);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("cold_peek", bus.peek_bits, 32'h01234567);
      checkOutput("cold_valid", {31'd0, bus.peek_valid}, 32'd1);
      applyStimulus(1, 32, 0, 0);
      checkOutput("skip32_1", bus.peek_bits, 32'h89ABCDEF);
      applyStimulus(1, 32, 0, 0);
      checkOutput("skip32_2", bus.peek_bits, 32'hFEDCBA98);
      applyStimulus(1, 32, 0, 0);
      checkOutput("skip32_3", bus.peek_bits, 32'h76543210);
      applyStimulus(1, 32, 0, 0);
      checkOutput("drained_valid", {31'd0, bus.peek_valid}, 32'd0);

      // Skip 3 then byte-align drops the remaining 5 bits of the first byte.
      applyStimulus(0, 0, 0, 1);
      fifo_q.push_back(W1);
      fifo_q.push_back(W2);
      waitValid();
      applyStimulus(1, 3, 0, 0);
      applyStimulus(0, 0, 1, 0);
      checkOutput("align_peek", bus.peek_bits, 32'h23456789);
      applyStimulus(0, 0, 1, 0);
      checkOutput("align_noop", bus.peek_bits, 32'h23456789);

      // Skip 20 while a word lands with 48 bits buffered.
      applyStimulus(0, 0, 0, 1);
      fifo_q.push_back(W1);
      fifo_q.push_back(W2);
      waitValid();
      applyStimulus(1, 16, 0, 0);
      applyStimulus(1, 20, 0, 0);
      checkOutput("splice_peek", bus.peek_bits, 32'h9ABCDEFF);
      applyStimulus(1, 0, 0, 0);
      checkOutput("skip0_noop", bus.peek_bits, 32'h9ABCDEFF);

      // Flush in the cycle after a read: that word is lost, the next is intact.
      applyStimulus(1, 32, 0, 0);
      fifo_q.push_back(W3);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("flush_valid", {31'd0, bus.peek_valid}, 32'd0);
      fifo_q.push_back(W4);
      waitValid();
      checkOutput("post_flush_peek", bus.peek_bits, 32'hCAFEF00D);

      // Skips of 32, 17, 0 and an align of 7 consume 56 bits.
      applyStimulus(0, 0, 0, 1);
      fifo_q.push_back(W1);
      fifo_q.push_back(W2);
      waitValid();
      applyStimulus(1, 32, 0, 0);
      applyStimulus(1, 17, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 1, 0);
`ifdef BS_BIT_COUNT_EN
      checkOutput("bit_count_56", bus.bit_count, 32'd56);
`endif
      checkOutput("count_peek", bus.peek_bits, {W1[7:0], W2[63:40]});

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         logic       r_skip;
         logic [5:0] r_len;
         logic       r_align;
         logic       r_flush;
         if (fifo_q.size() < 3 && $urandom_range(0, 2) != 0) begin
            fifo_q.push_back({$urandom, $urandom});
         end
         r_skip  = ($urandom_range(0, 1) == 1);
         r_len   = 6'($urandom_range(0, 32));
         r_align = ($urandom_range(0, 5) == 0);
         r_flush = ($urandom_range(0, 39) == 0);
         applyStimulus(r_skip, r_len, r_align, r_flush);
      end

      // aclr while a read is in flight: the word is lost, the next one is clean.
      applyStimulus(0, 0, 0, 1);
      fifo_q.push_back(W3);
      applyStimulus(0, 0, 0, 0);
      fifo_q.push_back(W4);
      doReset();
      fifo_q.push_back(W5);
      waitValid();
      checkOutput("post_reset_peek", bus.peek_bits, 32'h5A5AC3C3);
      applyStimulus(1, 32, 0, 0);
      checkOutput("post_reset_tail", bus.peek_bits, 32'h0F0F9696);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
